// File: rtl/data_buf_window_ctrl_pkg.sv
// Shared FSM state type and width helper for the convolution window controller.
package conv_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SCAN, DONE} state_t;

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < v) w++;
        return w;
    endfunction

endpackage

// File: rtl/data_buf_window_ctrl_window_addr_gen.sv
// Combinational K x K read-address fan-out: row_base + c + kr*IMG_W + kc for every port.
module window_addr_gen #(
    parameter int unsigned IMG_W      = 28,
    parameter int unsigned K          = 5,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CW         = 5
) (
    input  logic [ADDR_WIDTH-1:0]     row_base,
    input  logic [CW-1:0]             c,
    output logic [K*K*ADDR_WIDTH-1:0] rd_addr
);

    for (genvar kr = 0; kr < K; kr++) begin : g_row
        for (genvar kc = 0; kc < K; kc++) begin : g_col
            localparam int unsigned OFF = kr * IMG_W + kc;
            assign rd_addr[(kr*K+kc)*ADDR_WIDTH +: ADDR_WIDTH] =
                row_base + ADDR_WIDTH'(c) + ADDR_WIDTH'(OFF);
        end
    end

endmodule

// File: rtl/data_buf_window_ctrl.sv
// Loads one feature map into the multi-port buffer, then walks every K x K window
// and hands each one to the convolution core over a valid/ready handshake.
module data_buf_window_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W      = 28,
    parameter int unsigned IMG_H      = 28,
    parameter int unsigned K          = 5,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    input  logic                       pix_valid,
    input  logic [WIDTH-1:0]           pix_data,
    output logic                       pix_ready,
    output logic                       buf_wr_en,
    output logic [ADDR_WIDTH-1:0]      buf_wr_addr,
    output logic [WIDTH-1:0]           buf_wr_data,
    output logic [K*K*ADDR_WIDTH-1:0]  buf_rd_addr,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [15:0]                win_row,
    output logic [15:0]                win_col,
    output logic                       win_last
);

    localparam int unsigned NP    = K * K;
    localparam int unsigned N_PIX = IMG_W * IMG_H;
    localparam int unsigned OUT_W = IMG_W - K + 1;
    localparam int unsigned OUT_H = IMG_H - K + 1;
    localparam int unsigned PW    = clog2(N_PIX);
    localparam int unsigned CW    = clog2(OUT_W);
    localparam int unsigned RW    = clog2(OUT_H);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    state_t                  state;
    logic [PW-1:0]           pix_idx;
    logic [CW-1:0]           c, c_nxt;
    logic [RW-1:0]           r, r_nxt;
    logic [ADDR_WIDTH-1:0]   row_base, row_base_nxt;
    logic [NP*ADDR_WIDTH-1:0] addr_nxt;
    logic                    pix_acc, last_nxt;

    assign pix_acc = pix_valid && pix_ready;

    // Next window position; outside SCAN this is the first window, loaded in SETTLE.
    always_comb begin
        c_nxt        = c + CW'(1);
        r_nxt        = r;
        row_base_nxt = row_base;
        if (state != SCAN) begin
            c_nxt        = '0;
            r_nxt        = '0;
            row_base_nxt = BASE;
        end else if (c == CW'(OUT_W - 1)) begin
            c_nxt        = '0;
            r_nxt        = r + RW'(1);
            row_base_nxt = row_base + ADDR_WIDTH'(IMG_W);
        end
        last_nxt = (r_nxt == RW'(OUT_H - 1)) && (c_nxt == CW'(OUT_W - 1));
    end

    window_addr_gen #(
        .IMG_W      (IMG_W),
        .K          (K),
        .ADDR_WIDTH (ADDR_WIDTH),
        .CW         (CW)
    ) u_addr_gen (
        .row_base (row_base_nxt),
        .c        (c_nxt),
        .rd_addr  (addr_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            pix_ready   <= 1'b0;
            buf_wr_en   <= 1'b0;
            buf_wr_addr <= '0;
            buf_wr_data <= '0;
            buf_rd_addr <= '0;
            win_valid   <= 1'b0;
            win_row     <= '0;
            win_col     <= '0;
            win_last    <= 1'b0;
            pix_idx     <= '0;
            c           <= '0;
            r           <= '0;
            row_base    <= BASE;
        end else begin
            buf_wr_en <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        busy      <= 1'b1;
                        pix_ready <= 1'b1;
                        pix_idx   <= '0;
                    end
                end
                LOAD: begin
                    if (pix_acc) begin
                        buf_wr_en   <= 1'b1;
                        buf_wr_addr <= BASE + ADDR_WIDTH'(pix_idx);
                        buf_wr_data <= pix_data;
                        pix_idx     <= pix_idx + PW'(1);
                        if (pix_idx == PW'(N_PIX - 1)) begin
                            pix_ready <= 1'b0;
                            state     <= SETTLE;
                        end
                    end
                end
                // Last write commits this cycle; first window addresses go out next.
                SETTLE: begin
                    state       <= SCAN;
                    c           <= c_nxt;
                    r           <= r_nxt;
                    row_base    <= row_base_nxt;
                    buf_rd_addr <= addr_nxt;
                    win_row     <= 16'(r_nxt);
                    win_col     <= 16'(c_nxt);
                    win_last    <= last_nxt;
                end
                SCAN: begin
                    if (!win_valid) begin
                        win_valid <= 1'b1;
                    end else if (win_ready) begin
                        win_valid <= 1'b0;
                        if (win_last) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            win_last <= 1'b0;
                        end else begin
                            c           <= c_nxt;
                            r           <= r_nxt;
                            row_base    <= row_base_nxt;
                            buf_rd_addr <= addr_nxt;
                            win_row     <= 16'(r_nxt);
                            win_col     <= 16'(c_nxt);
                            win_last    <= last_nxt;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/data_buf_window_ctrl.md
Name: data_buf_window_ctrl

Overview:
- Sequencer for the multi-port convolution data buffer (1 write port, K*K read ports, 1-cycle registered read latency).
- Loads one IMG_W x IMG_H feature map from a valid/ready pixel stream into the buffer, then scans every valid K x K window.
- For each window it drives all K*K read addresses in parallel and hands the window to the convolution core with a valid/ready handshake.

Parameters:
- IMG_W, 28, feature-map width in pixels
- IMG_H, 28, feature-map height in pixels
- K, 5, kernel size; number of read ports NP = K*K (localparam)
- WIDTH, 16, pixel data width
- ADDR_WIDTH, 32, buffer address width
- BASE_ADDR, 0, buffer address of pixel (0,0)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle pulse, begins load+scan; ignored unless IDLE
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  1-cycle pulse after the final window handshake
- pix_valid  in  1  input pixel valid
- pix_data  in  WIDTH  input pixel, raster order (row-major)
- pix_ready  out  1  high only in LOAD
- buf_wr_en  out  1  buffer write enable (registered)
- buf_wr_addr  out  ADDR_WIDTH  buffer write address (registered)
- buf_wr_data  out  WIDTH  buffer write data (registered)
- buf_rd_addr  out  NP*ADDR_WIDTH  packed read addresses; port i=kr*K+kc occupies bits [(i+1)*ADDR_WIDTH-1 : i*ADDR_WIDTH]
- win_valid  out  1  buffer read data for the current window is valid
- win_ready  in  1  convolution core accepts the window
- win_row  out  16  output row r of the current window
- win_col  out  16  output column c of the current window
- win_last  out  1  current window is the final one, (IMG_H-K, IMG_W-K)

Behaviour:
- Reset: state=IDLE. busy, done, pix_ready, buf_wr_en, win_valid and win_last are 0. buf_wr_addr, buf_wr_data, buf_rd_addr, win_row and win_col are 0. Reset mid-operation aborts immediately; no resume.
- States: IDLE -> LOAD (on start) -> SETTLE -> SCAN -> DONE -> IDLE.
- LOAD:
  - pix_ready=1.
  - Each accepted pixel n (pix_valid&&pix_ready) produces buf_wr_en=1, buf_wr_addr=BASE_ADDR+n, buf_wr_data=pix_data on the next cycle. buf_wr_en is 0 otherwise.
  - pix_valid gaps are allowed.
  - After pixel IMG_W*IMG_H-1 is accepted (cycle T): pix_ready=0 from T+1, state=SETTLE at T+1.
- SETTLE: one cycle. Guarantees the last write commits before the first read. SCAN entered at T+2 with r=c=0.
- SCAN:
  - buf_rd_addr[i] = BASE_ADDR + (r+kr)*IMG_W + (c+kc). Computed from a row_base register (BASE_ADDR + r*IMG_W) plus c plus constant offsets; no multiplier in the loop.
  - Addresses change only on the cycle after a handshake.
  - win_valid rises one cycle after addresses change (first window: win_valid at T+3). It stays high, with addresses, win_row, win_col and win_last held, until win_valid&&win_ready.
  - On handshake at cycle H: advance c (wrap to 0 at IMG_W-K+1, then r+=1, row_base+=IMG_W). New addresses at H+1, win_valid=0 at H+1, win_valid=1 at H+2. Throughput is 1 window per 2 cycles with win_ready held high.
  - Total windows: (IMG_H-K+1)*(IMG_W-K+1).
  - Handshake with win_last=1 -> DONE at H+1.
- DONE: done=1 for exactly one cycle, busy=0 the same cycle, then IDLE. buf_rd_addr holds its last value.
- start while busy: ignored. start in the same cycle as done: ignored.
- win_ready high while win_valid=0: no effect.
- Address arithmetic is unsigned, ADDR_WIDTH wide. Counters r, c and the pixel index have width clog2 of their maxima. win_row and win_col are zero-extended to 16 bits.

Decomposition:
- Shared package conv_pkg:
  - state enum {IDLE, LOAD, SETTLE, SCAN, DONE}
  - localparams NP=K*K, N_PIX=IMG_W*IMG_H, OUT_W=IMG_W-K+1, OUT_H=IMG_H-K+1
  - clog2 function
- One sub-module: window_addr_gen. Inputs: row_base, c. Output: packed NP address offsets, via a generate loop over kr/kc. Purely combinational with constant offsets.
- The FSM, counters and handshake stay in the top module.

Test Plan (IMG_W=IMG_H=6, K=3, BASE_ADDR=100 unless noted):
- Reset, then start with pixels 0..35 streamed back-to-back -> buf_wr_addr 100..135, buf_wr_data 0..35. pix_ready falls after pixel 35. First win_valid exactly 3 cycles after the last accept, with buf_rd_addr ports 0..8 = {100,101,102,106,107,108,112,113,114}.
- win_ready held high -> 16 windows. (row,col) runs (0,0),(0,1)...(0,3),(1,0)...(3,3). Window (1,0) port 0=106. Window (3,3) port 8=135 with win_last=1. done pulses 1 cycle after the 16th handshake; busy=0 that cycle.
- win_ready held low 10 cycles on window (2,1) -> win_valid, addresses (port 0=113), win_row=2 and win_col=1 all stable for those 10 cycles. Exactly one handshake when win_ready returns.
- pix_valid toggling every other cycle, plus a start pulse mid-LOAD -> the start is ignored. Write addresses stay contiguous 100..135 with no duplicates. Scan proceeds normally.
- rst_n asserted during SCAN at window (1,2) -> all outputs 0 asynchronously. After release, a new start with pixels 0..35 gives first-window addresses 100.. as in scenario 1.
- K=1, IMG_W=IMG_H=2, BASE_ADDR=0 -> 4 windows with single-port addresses 0,1,2,3. win_last on the 4th window, then done.
